// File: rtl/pixel_scan_controller.sv
// Raster scan sequencer feeding pixel_sampler: walks the frame, tracks in-flight samples, flags completion.
// Optional stall_cycles performance counter enabled by defining PIXEL_SCAN_PERF_EN.
module pixel_scan_controller #(
  parameter int PIXEL_W     = 800,
  parameter int PIXEL_H     = 600,
  parameter int SAMPLER_LAT = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        abort,
  input  logic        out_ready,
  output logic [9:0]  pixel_x,
  output logic [9:0]  pixel_y,
  output logic        pixel_valid,
  output logic        stall,
  output logic        sample_valid,
  output logic        busy,
  output logic        frame_done,
  output logic [15:0] frame_count
`ifdef PIXEL_SCAN_PERF_EN
  ,
  output logic [31:0] stall_cycles
`endif
);

  // state | meaning
  // IDLE  | waiting for start, coords parked at (0,0)
  // SCAN  | issuing one pixel per unstalled cycle
  // DRAIN | all pixels issued, waiting for the sampler pipe to empty
  // DONE  | one-cycle frame_done pulse, frame_count advances
  typedef enum logic [1:0] {IDLE, SCAN, DRAIN, DONE} state_t;

  localparam logic [9:0] XMAX = 10'(PIXEL_W - 1);
  localparam logic [9:0] YMAX = 10'(PIXEL_H - 1);

  state_t                 state, state_d;
  logic [9:0]             x, y, x_d, y_d;
  logic [SAMPLER_LAT-1:0] pipe, pipe_shift, pipe_d;
  logic                   abort_busy;

  assign busy         = (state != IDLE);
  assign stall        = busy & ~out_ready;
  assign pixel_valid  = (state == SCAN) & ~stall;
  assign sample_valid = pipe[SAMPLER_LAT-1] & ~stall;
  assign abort_busy   = abort & busy;
  assign pixel_x      = x;
  assign pixel_y      = y;

  always_comb begin
    pipe_shift    = '0;
    pipe_shift[0] = pixel_valid;
    for (int i = 1; i < SAMPLER_LAT; i++) pipe_shift[i] = pipe[i-1];
    pipe_d = stall ? pipe : pipe_shift;
  end

  always_comb begin
    state_d    = state;
    x_d        = x;
    y_d        = y;
    frame_done = 1'b0;
    case (state)
      IDLE: begin
        x_d = '0;
        y_d = '0;
        if (start && !abort) state_d = SCAN;
      end
      SCAN: begin
        if (pixel_valid) begin
          if (x == XMAX) begin
            x_d = '0;
            y_d = (y == YMAX) ? 10'd0 : y + 10'd1;
            if (y == YMAX) state_d = DRAIN;
          end else begin
            x_d = x + 10'd1;
          end
        end
      end
      DRAIN: begin
        x_d = '0;
        y_d = '0;
        if (pipe_d == '0) state_d = DONE;
      end
      DONE: begin
        frame_done = 1'b1;
        state_d    = IDLE;
      end
      default: state_d = IDLE;
    endcase
    // Abort overrides everything, including the completion pulse.
    if (abort_busy) begin
      state_d    = IDLE;
      x_d        = '0;
      y_d        = '0;
      frame_done = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      x           <= '0;
      y           <= '0;
      pipe        <= '0;
      frame_count <= '0;
    end else begin
      state <= state_d;
      x     <= x_d;
      y     <= y_d;
      if (abort_busy) pipe <= '0;
      else            pipe <= pipe_d;
      if (frame_done) frame_count <= frame_count + 16'd1;
    end
  end

`ifdef PIXEL_SCAN_PERF_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                 stall_cycles <= '0;
    else if (state == IDLE && start && !abort)  stall_cycles <= '0;
    else if (stall && stall_cycles != '1)       stall_cycles <= stall_cycles + 32'd1;
  end
`endif

endmodule

// File: tb/tb_pixel_scan_controller.sv
// Directed bench for pixel_scan_controller: 4x3 frame with LAT=2 plus a 1x1 LAT=1 instance.
// Issue slots are queued as expected and matched against sample_valid pulses by unstalled-cycle distance.
module tb_pixel_scan_controller;
  localparam int W = 4, H = 3, LAT = 2;

  logic        clk = 1'b0;
  logic        rst_n, start, abort, out_ready;
  logic [9:0]  pixel_x, pixel_y;
  logic        pixel_valid, stall, sample_valid, busy, frame_done;
  logic [15:0] frame_count;
  logic        start1, abort1, ready1;
  logic [9:0]  px1, py1;
  logic        pv1, st1, sv1, busy1, fd1;
  logic [15:0] fc1;
`ifdef PIXEL_SCAN_PERF_EN
  logic [31:0] stall_cycles, stall_cycles1;
`endif

  int total = 0;
  int bad = 0;
  int exp_frames = 0;
  int q_issue[$];

  always #5 clk = ~clk;

  pixel_scan_controller #(.PIXEL_W(W), .PIXEL_H(H), .SAMPLER_LAT(LAT)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .out_ready(out_ready),
    .pixel_x(pixel_x), .pixel_y(pixel_y), .pixel_valid(pixel_valid), .stall(stall),
    .sample_valid(sample_valid), .busy(busy), .frame_done(frame_done),
    .frame_count(frame_count)
`ifdef PIXEL_SCAN_PERF_EN
    , .stall_cycles(stall_cycles)
`endif
  );

  pixel_scan_controller #(.PIXEL_W(1), .PIXEL_H(1), .SAMPLER_LAT(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .abort(abort1), .out_ready(ready1),
    .pixel_x(px1), .pixel_y(py1), .pixel_valid(pv1), .stall(st1),
    .sample_valid(sv1), .busy(busy1), .frame_done(fd1), .frame_count(fc1)
`ifdef PIXEL_SCAN_PERF_EN
    , .stall_cycles(stall_cycles1)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Start at cycle 0; optional stall window [s0,s1], start re-pulse and abort cycles (0 = none).
  task automatic run_frame(input int s0, input int s1, input int restart_c, input int abort_c);
    int k, done_c, nc, u, ex, ey, ns, iu;
    logic stl, epv;
    k      = (s1 >= s0) ? s1 - s0 + 1 : 0;
    done_c = W * H + LAT + 1 + k;
    nc     = (abort_c > 0) ? abort_c + 6 : done_c + 1;
    q_issue.delete();
    u = 0; ex = 0; ey = 0; ns = 0;
    @(posedge clk); #1;
    start = 1'b1; abort = 1'b0; out_ready = 1'b1;
    for (int c = 1; c <= nc; c++) begin
      @(posedge clk); #1;
      start     = (c == restart_c);
      abort     = (c == abort_c);
      stl       = (c >= s0 && c <= s1);
      out_ready = !stl;
      #1;
`ifdef PIXEL_SCAN_PERF_EN
      if (c == 1) chk("stall_cycles_clear", stall_cycles, 0);
`endif
      if (abort_c > 0 && c > abort_c) begin
        chk($sformatf("abort_busy c%0d", c), busy, 0);
        chk($sformatf("abort_pv c%0d", c), pixel_valid, 0);
        chk($sformatf("abort_fd c%0d", c), frame_done, 0);
        chk($sformatf("abort_xy c%0d", c), {pixel_x, pixel_y}, 0);
        continue;
      end
      epv = (c <= W * H + k) && !stl;
      if (!stl) u++;
      chk($sformatf("busy c%0d", c), busy, c <= done_c);
      chk($sformatf("pixel_valid c%0d", c), pixel_valid, epv);
      chk($sformatf("stall c%0d", c), stall, stl);
      if (epv || stl) begin
        chk($sformatf("pixel_x c%0d", c), pixel_x, ex);
        chk($sformatf("pixel_y c%0d", c), pixel_y, ey);
      end
      if (stl) chk($sformatf("sv_in_stall c%0d", c), sample_valid, 0);
      if (epv) begin
        q_issue.push_back(u);
        ex++;
        if (ex == W) begin ex = 0; ey++; end
      end
      if (sample_valid) begin
        chk($sformatf("sv_expected c%0d", c), q_issue.size() > 0, 1);
        if (q_issue.size() > 0) begin
          iu = q_issue.pop_front();
          chk($sformatf("sv_latency c%0d", c), u - iu, LAT);
          ns++;
        end
      end
      chk($sformatf("frame_done c%0d", c), frame_done, (abort_c == 0) && (c == done_c));
      if (abort_c == 0 && c == done_c) exp_frames++;
    end
    start = 1'b0; abort = 1'b0; out_ready = 1'b1;
    if (abort_c == 0) begin
      chk("sample_total", ns, W * H);
      chk("queue_empty", q_issue.size(), 0);
`ifdef PIXEL_SCAN_PERF_EN
      chk("stall_cycles", stall_cycles, k);
`endif
    end
    chk("frame_count", frame_count, exp_frames);
  endtask

  initial begin
    int f1;
    rst_n = 1'b0; start = 1'b0; abort = 1'b0; out_ready = 1'b0;
    start1 = 1'b0; abort1 = 1'b0; ready1 = 1'b1;
    #3;
    chk("rst_busy", busy, 0);
    chk("rst_xy", {pixel_x, pixel_y}, 0);
    chk("rst_flags", {pixel_valid, stall, sample_valid, frame_done}, 0);
    chk("rst_count", frame_count, 0);
    #19 rst_n = 1'b1;

    run_frame(1, 0, 0, 0);        // clean frame
    run_frame(5, 7, 0, 0);        // backpressure cycles 5-7
    run_frame(1, 0, 0, 6);        // abort at cycle 6
    run_frame(1, 0, 0, 0);        // full frame after abort
    run_frame(1, 0, 5, 0);        // start re-pulsed mid-frame

    // start and abort together in IDLE, out_ready low: nothing happens
    @(posedge clk); #1;
    start = 1'b1; abort = 1'b1; out_ready = 1'b0;
    for (int c = 1; c <= 4; c++) begin
      @(posedge clk); #1;
      start = 1'b0; abort = 1'b0;
      #1;
      chk($sformatf("idle_busy c%0d", c), busy, 0);
      chk($sformatf("idle_stall c%0d", c), stall, 0);
      chk($sformatf("idle_pv c%0d", c), pixel_valid, 0);
    end
    out_ready = 1'b1;

    // 1x1 frame, LAT=1: pixel at 1, sample at 2, done at 3
    f1 = 0;
    for (int fr = 0; fr < 3; fr++) begin
      @(posedge clk); #1;
      start1 = 1'b1;
      for (int c = 1; c <= 4; c++) begin
        @(posedge clk); #1;
        start1 = 1'b0;
        #1;
        chk($sformatf("one_pv f%0d c%0d", fr, c), pv1, c == 1);
        chk($sformatf("one_sv f%0d c%0d", fr, c), sv1, c == 2);
        chk($sformatf("one_fd f%0d c%0d", fr, c), fd1, c == 3);
        chk($sformatf("one_busy f%0d c%0d", fr, c), busy1, c <= 3);
        chk($sformatf("one_xy f%0d c%0d", fr, c), {px1, py1}, 0);
      end
      f1++;
      chk("one_count", fc1, f1);
    end

    // asynchronous reset mid-frame
    @(posedge clk); #1;
    start = 1'b1;
    for (int c = 1; c <= 5; c++) begin
      @(posedge clk); #1;
      start = 1'b0;
    end
    #2 rst_n = 1'b0;
    #1;
    chk("arst_busy", busy, 0);
    chk("arst_xy", {pixel_x, pixel_y}, 0);
    chk("arst_flags", {pixel_valid, sample_valid, frame_done}, 0);
    chk("arst_count", frame_count, 0);
    exp_frames = 0;
    @(posedge clk); #1;
    chk("arst_hold_busy", busy, 0);
    @(negedge clk);
    rst_n = 1'b1;
    run_frame(1, 0, 0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
